// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory port between the fetch (imem) and
// load/store (dmem) requesters, with a single outstanding transaction.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties instead of
// letting dmem win every tie.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_req_valid,
  output logic                  imem_req_ready,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_resp_valid,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  dmem_req_valid,
  output logic                  dmem_req_ready,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_we,
  input  logic [MASK_WIDTH-1:0] dmem_wmask,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_resp_valid,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;      // 1 = dmem owns the transaction
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_imem_rdata;
  logic [DATA_WIDTH-1:0] r_dmem_rdata;
  logic                  r_imem_resp;
  logic                  r_dmem_resp;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_accept;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  r_last_grant; // 1 = dmem was granted last
`endif

  // Arbitration, next-state and handshake outputs; ready is held low during reset
  always_comb begin
    w_grant_i     = 1'b0;
    w_grant_d     = 1'b0;
    w_next        = r_state;
    mem_req_valid = 1'b0;
    if (r_state == ST_IDLE && !rst) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (imem_req_valid && dmem_req_valid) begin
        w_grant_i = r_last_grant;
        w_grant_d = !r_last_grant;
      end else begin
        w_grant_i = imem_req_valid;
        w_grant_d = dmem_req_valid;
      end
`else
      w_grant_d = dmem_req_valid;
      w_grant_i = imem_req_valid && !dmem_req_valid;
`endif
    end
    w_accept = w_grant_i || w_grant_d;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT:  if (mem_resp_valid) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign imem_req_ready = w_grant_i;
  assign dmem_req_ready = w_grant_d;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Latch the granted request; fetches are always reads with no byte enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_grant_d;
      r_addr  <= w_grant_d ? dmem_addr : imem_addr;
      r_we    <= w_grant_d & dmem_we;
      r_wmask <= w_grant_d ? dmem_wmask : '0;
      r_wdata <= w_grant_d ? dmem_wdata : '0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the last accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_grant <= 1'b0;
    else if (w_accept) r_last_grant <= w_grant_d;
  end
`endif

  // Capture the response for the owner; responses outside WAIT are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_imem_resp  <= 1'b0;
      r_dmem_resp  <= 1'b0;
    end else begin
      r_imem_resp <= 1'b0;
      r_dmem_resp <= 1'b0;
      if (r_state == ST_WAIT && mem_resp_valid) begin
        if (r_owner) begin
          r_dmem_rdata <= mem_rdata;
          r_dmem_resp  <= 1'b1;
        end else begin
          r_imem_rdata <= mem_rdata;
          r_imem_resp  <= 1'b1;
        end
      end
    end
  end

  assign mem_addr        = r_addr;
  assign mem_we          = r_we;
  assign mem_wmask       = r_wmask;
  assign mem_wdata       = r_wdata;
  assign imem_rdata      = r_imem_rdata;
  assign dmem_rdata      = r_dmem_rdata;
  assign imem_resp_valid = r_imem_resp;
  assign dmem_resp_valid = r_dmem_resp;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: table of transactions driven
// through a scripted memory, responses checked through a scoreboard queue.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_addr, imem_rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  core_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        iv, dv;
    logic [63:0] iaddr, daddr;
    logic        we;
    logic [7:0]  wmask;
    logic [63:0] wdata, rdata;
    int unsigned rdy, rsp;
    logic        spur;
    logic        exp_d;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [63:0] rdata;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[10];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [63:0] exp_ir = '0;
  logic [63:0] exp_dr = '0;
  logic        started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic iv, input logic dv, input logic [63:0] ia,
                              input logic [63:0] da, input logic we, input logic [7:0] m,
                              input logic [63:0] wd, input logic [63:0] rd,
                              input int unsigned rdy, input int unsigned rsp,
                              input logic spur, input logic ed);
    vec_t v;
    v.iv = iv; v.dv = dv; v.iaddr = ia; v.daddr = da; v.we = we; v.wmask = m;
    v.wdata = wd; v.rdata = rd; v.rdy = rdy; v.rsp = rsp; v.spur = spur; v.exp_d = ed;
    return v;
  endfunction

  // Scoreboard consumer plus continuous rdata-hold checks
  always @(negedge clk) begin
    if (started && !rst) begin
      if (imem_resp_valid || dmem_resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("resp_owner", {62'd0, dmem_resp_valid, imem_resp_valid},
              e.is_d ? 64'd2 : 64'd1);
          if (e.is_d) exp_dr = e.rdata;
          else        exp_ir = e.rdata;
        end
      end
      chk("imem_rdata", imem_rdata, exp_ir);
      chk("dmem_rdata", dmem_rdata, exp_dr);
    end
  end

  // One full transaction starting at a negedge in IDLE; returns at the
  // negedge of the response-pulse cycle, where the next request may start.
  task automatic do_txn(input vec_t v);
    logic [63:0] ea;
    logic        ewe;
    logic [7:0]  em;
    ea  = v.exp_d ? v.daddr : v.iaddr;
    ewe = v.exp_d & v.we;
    em  = v.exp_d ? v.wmask : 8'h00;
    imem_req_valid = v.iv; dmem_req_valid = v.dv;
    imem_addr = v.iaddr; dmem_addr = v.daddr;
    dmem_we = v.we; dmem_wmask = v.wmask; dmem_wdata = v.wdata;
    #1;
    chk("imem_req_ready_c0", {63'd0, imem_req_ready}, {63'd0, !v.exp_d});
    chk("dmem_req_ready_c0", {63'd0, dmem_req_ready}, {63'd0, v.exp_d});
    sb.push_back('{v.exp_d, v.rdata});
    @(negedge clk);
    if (v.spur) begin
      mem_resp_valid = 1'b1;
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    for (int unsigned k = 0; k <= v.rdy; k++) begin
      mem_req_ready = (k == v.rdy);
      #1;
      chk("issue_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("issue_addr", mem_addr, ea);
      chk("issue_we", {63'd0, mem_we}, {63'd0, ewe});
      chk("issue_wmask", {56'd0, mem_wmask}, {56'd0, em});
      if (v.exp_d) chk("issue_wdata", mem_wdata, v.wdata);
      chk("issue_readies", {62'd0, dmem_req_ready, imem_req_ready}, 64'd0);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    chk("wait_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("wait_readies", {62'd0, dmem_req_ready, imem_req_ready}, 64'd0);
    for (int unsigned k = 0; k < v.rsp; k++) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("resp_pulse", {62'd0, dmem_resp_valid, imem_resp_valid}, v.exp_d ? 64'd2 : 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(1, 0, 64'h1000, 64'h0, 0, 8'h00, 64'h0, 64'h00000013_00000093, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 64'h0, 64'h2008, 1, 8'h0F, 64'hDEADBEEF, 64'h1111_2222_3333_4444, 0, 0, 0, 1);
    tbl[2] = mk(0, 1, 64'h0, 64'h3000, 0, 8'h00, 64'h0, 64'hCAFE_F00D_0000_0001, 5, 2, 0, 1);
    tbl[3] = mk(1, 0, 64'h1008, 64'h0, 0, 8'h00, 64'h0, 64'h0000_0000_ABCD_0003, 2, 1, 1, 0);
    tbl[4] = mk(1, 1, 64'h1010, 64'h4000, 1, 8'hF0, 64'h5555_0000_0000_0000, 64'h44, 0, 0, 0, 1);
    tbl[5] = mk(1, 1, 64'h1010, 64'h4008, 0, 8'h00, 64'h0, 64'h55, 0, 0, 0, RR ? 1'b0 : 1'b1);
    tbl[6] = mk(1, 1, 64'h1010, 64'h4010, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h66, 0, 1, 0, 1);
    tbl[7] = mk(1, 1, 64'h1010, 64'h4018, 0, 8'h00, 64'h0, 64'h77, 1, 0, 0, RR ? 1'b0 : 1'b1);
    tbl[8] = mk(1, 0, 64'h1010, 64'h0, 0, 8'h00, 64'h0, 64'h88, 0, 0, 0, 0);
    tbl[9] = mk(0, 1, 64'h0, 64'h5000, 0, 8'h00, 64'h0, 64'h99, 0, 0, 0, 1);

    rst = 1'b1;
    imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
    imem_addr = '0; dmem_addr = '0; dmem_we = 1'b0; dmem_wmask = '0; dmem_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_readies", {62'd0, dmem_req_ready, imem_req_ready}, 64'd0);
    chk("rst_resp", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);
    chk("rst_rdata", imem_rdata | dmem_rdata, 64'd0);
    chk("rst_mem", {63'd0, mem_req_valid} | mem_addr | {63'd0, mem_we} | {56'd0, mem_wmask} | mem_wdata, 64'd0);
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Spurious response while idle
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD_0000_DEAD_0000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("idle_spur_resp", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);
    @(negedge clk);

    // Reset while waiting for the response
    dmem_req_valid = 1'b1; dmem_addr = 64'h6000; dmem_we = 1'b1;
    dmem_wmask = 8'h3C; dmem_wdata = 64'h1234;
    #1;
    chk("rstw_ready", {63'd0, dmem_req_ready}, 64'd1);
    sb.push_back('{1'b1, 64'hAA});
    @(negedge clk);
    dmem_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    exp_ir = '0; exp_dr = '0;
    sb.delete(sb.size() - 1);
    #1;
    chk("rstw_mem", {63'd0, mem_req_valid} | mem_addr | {63'd0, mem_we} | {56'd0, mem_wmask} | mem_wdata, 64'd0);
    chk("rstw_resp", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);
    chk("rstw_rdata", imem_rdata | dmem_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 64'hAA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);
    @(negedge clk);
    chk("late_resp_next", {62'd0, dmem_resp_valid, imem_resp_valid}, 64'd0);

    // Recovery after reset
    do_txn(mk(1, 0, 64'h1020, 64'h0, 0, 8'h00, 64'h0, 64'hFEED_FACE_0000_0020, 0, 0, 0, 0));
    imem_req_valid = 1'b0;
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the single 64-bit unified memory port between the core's instruction-fetch requester (imem) and load/store requester (dmem). The arbiter grants one requester at a time, registers the granted request, and drives it to memory with a valid/ready handshake. It then waits for the memory response and returns the registered read data to the owning requester. It sits between the IF/MEM pipeline stages and the memory/bus interface, and allows exactly one transaction outstanding.

## Interface
- ADDR_WIDTH, 64, address width (matches CorePack addr_t)
- DATA_WIDTH, 64, data width (matches CorePack data_t)
- MASK_WIDTH, DATA_WIDTH/8, byte write-mask width
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  in  1  fetch request pending
- imem_req_ready  out  1  fetch request accepted this cycle
- imem_addr  in  ADDR_WIDTH  fetch address
- imem_resp_valid  out  1  one-cycle pulse: imem_rdata valid
- imem_rdata  out  DATA_WIDTH  fetch read data
- dmem_req_valid  in  1  data request pending
- dmem_req_ready  out  1  data request accepted this cycle
- dmem_addr  in  ADDR_WIDTH  data address
- dmem_we  in  1  1 = write, 0 = read
- dmem_wmask  in  MASK_WIDTH  byte enables for writes
- dmem_wdata  in  DATA_WIDTH  write data
- dmem_resp_valid  out  1  one-cycle pulse: read data valid or write acknowledged
- dmem_rdata  out  DATA_WIDTH  data read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_we, mem_wmask, mem_wdata  out  ADDR_WIDTH/1/MASK_WIDTH/DATA_WIDTH  registered request fields
- mem_resp_valid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states are IDLE, ISSUE and WAIT; reset state is IDLE.
- IDLE:
  - The arbiter picks a winner among the asserted *_req_valid inputs.
  - The winner's *_req_ready is driven combinationally high. The loser's ready stays 0.
  - On valid&&ready, the arbiter latches addr/we/wmask/wdata and the owner ID, then moves to ISSUE.
  - imem requests are latched with we=0 and wmask=0.
- ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready=1 the FSM moves to WAIT.
  - mem_resp_valid is ignored in this state.
- WAIT:
  - On mem_resp_valid=1 the arbiter registers mem_rdata into the owner's rdata register and pulses the owner's resp_valid on the next cycle. The FSM returns to IDLE.
- Writes produce a dmem_resp_valid pulse as an acknowledgement. dmem_rdata is undefined-but-stable for writes: it is loaded with mem_rdata as-is.
- imem_rdata and dmem_rdata hold their value until the next response to the same requester.
- mem_resp_valid in IDLE is dropped.
- No *_req_ready is asserted in ISSUE or WAIT.
- Reset values:
  - imem_req_ready=0, dmem_req_ready=0
  - imem_resp_valid=0, dmem_resp_valid=0
  - imem_rdata=0, dmem_rdata=0
  - mem_req_valid=0, mem_addr=0, mem_we=0, mem_wmask=0, mem_wdata=0
- Reset mid-transaction:
  - The FSM is forced to IDLE immediately (asynchronously) and mem_req_valid drops.
  - The in-flight response is lost. Memory is reset in the same domain.

## Timing
- Cycle 0 (IDLE): handshake with the requester.
- Cycle 1: mem_req_valid=1. If mem_req_ready=1 in that cycle, the FSM is in WAIT from cycle 2.
- Response: memory asserts mem_resp_valid no earlier than cycle 2. The owner's resp_valid is high the following cycle.
- Minimum request-to-response latency is 3 cycles.
- The cycle in which resp_valid is high is IDLE, so a new request can be accepted in that same cycle. Peak throughput is one transaction per 3 cycles.
- *_req_ready is a combinational function of state, the *_req_valid inputs and the arbitration state. It never depends on mem_* inputs.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register (reset = imem) is updated on every accepted request.
  - When both requesters are valid in IDLE, the requester not granted last wins. A lone requester always wins.
- Undefined:
  - Fixed priority: dmem wins every tie. This is required for in-order pipeline progress.
  - last_grant is not implemented.

## Test plan
- Single fetch, imem_addr=0x1000, memory ready immediately, response 1 cycle later with rdata=0x00000013_00000093 -> mem_addr=0x1000 and mem_we=0 in cycle 1; imem_resp_valid pulse in cycle 3 with that data; dmem outputs unchanged.
- dmem write, addr=0x2008, wmask=0x0F, wdata=0xDEADBEEF -> mem_we=1 and mem_wmask=0x0F; dmem_resp_valid pulses once after the ack; imem_resp_valid stays 0.
- mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req_valid and all fields stay stable; no ready to either requester; transfer occurs on the 6th cycle.
- Both requesters valid continuously for 4 transactions:
  - Without the macro -> 4 dmem grants, then imem.
  - With ARB_ROUND_ROBIN_EN -> grant order dmem, imem, dmem, imem.
- rst asserted during WAIT -> all outputs return to reset values in the same cycle; a late mem_resp_valid after reset release produces no resp_valid pulse.
- Spurious mem_resp_valid while in IDLE or ISSUE -> ignored; no resp_valid pulse and rdata registers unchanged.
